fpu16_multiplier: RTL and testbench
===================================

Name: fpu16_multiplier

Overview:
- Pipelined IEEE 754 binary16 (half-precision) floating-point multiplier.
- Takes two half-precision operands every cycle and produces their rounded product one clock later.
- Used as the multiply datapath element of the FPU16 arithmetic cluster.
- Fully pipelined: no handshake, one result per clock.

Parameters:
- None. The format is fixed at binary16: 1 sign bit, 5 exponent bits (bias 15), 10 fraction bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  16  operand A, binary16.
- b  input  16  operand B, binary16.
- result  output  16  registered product a*b, binary16.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low.
  - While rst_n=0, result=16'h0000. Release is sampled on the next rising clk edge.
- Latency:
  - result is registered.
  - On each rising edge, result loads the product of the a/b values present before that edge.
  - Latency is 1 cycle, throughput 1 per cycle.
  - The multiply/normalize/round logic is combinational between the input pins and the result register. No input registers.
- Sign: sign = a[15] XOR b[15], for all cases including zero, Inf and NaN-free results.
- Decode:
  - exp=0 and frac=0 is zero.
  - exp=0 and frac≠0 is subnormal, significand 0.frac, effective exponent 1-15.
  - exp=31 and frac=0 is Inf.
  - exp=31 and frac≠0 is NaN.
  - Otherwise normal, significand 1.frac.
- Significand product: 11x11-bit unsigned multiply to 22 bits.
- Exponent: unbiased sum ea+eb, computed in signed arithmetic at least 8 bits wide to cover under/overflow.
- Normalization:
  - Left-shift by leading-zero count so the product is normalized. Needed when subnormal inputs are present.
  - Adjust the exponent for the product's 2.x or 1.x form.
- Underflow:
  - If the biased exponent would be ≤0, right-shift the significand into subnormal range.
  - Shifted-out bits are OR-collected into the sticky bit.
  - Biased exponent becomes 0.
- Rounding:
  - Round-to-nearest, ties-to-even, using guard, round and sticky bits.
  - A mantissa carry-out increments the exponent.
  - A subnormal that rounds up to 1.0×2^-14 becomes the smallest normal (exp=1).
- Overflow: if the biased exponent after rounding is ≥31, result = ±Inf (exp=31, frac=0).
- Special cases, highest priority first:
  1. Either operand NaN → canonical quiet NaN 16'h7E00 (sign 0).
  2. Inf × zero → 16'h7E00.
  3. Inf × nonzero → signed Inf.
  4. Zero × finite → signed zero.
- No exception flags, no alternate rounding modes.
- Reset mid-operation: asserting rst_n discards the in-flight product immediately. The first valid result appears one edge after release.

Decomposition:
- Shared package fpu16_pkg holds:
  - Widths and bias: EXP_W=5, FRAC_W=10, BIAS=15.
  - Constants QNAN=16'h7E00, POS_INF=16'h7C00.
  - A packed struct fp16_t {sign, exp, frac}.
- One natural sub-module: fpu16_round_norm.
  - Inputs: sign, signed exponent, 22-bit product.
  - Does the leading-zero normalization, subnormal shift, RNE rounding and overflow saturation.
  - Outputs the packed 16-bit value.
- The top module does decode, special-case select, the multiply and the output register.

Test Plan:
- Reset: hold rst_n=0 with a=16'h3C00, b=16'h3C00 → result=16'h0000. After release and one edge → 16'h3C00.
- Normal products, one result per cycle, each checked one edge later:
  - a=16'hC524, b=16'h4D90 → 16'hD726.
  - a=16'h562D, b=16'h5058 → 16'h6AB5 (round-up case).
  - a=16'hD1AE, b=16'h4947 → 16'hDF7E.
- Specials:
  - 16'h7C00 × 16'h0000 → 16'h7E00.
  - 16'h7E01 × 16'h3C00 → 16'h7E00.
  - 16'hFC00 × 16'h4000 → 16'hFC00.
  - 16'h8000 × 16'h3C00 → 16'h8000.
- Overflow: 16'h7BFF × 16'h7BFF → 16'h7C00. 16'hFBFF × 16'h7BFF → 16'hFC00.
- Subnormal/underflow:
  - 16'h0001 × 16'h3C00 → 16'h0001.
  - 16'h0001 × 16'h3800 → 16'h0000 (tie to even).
  - 16'h0001 × 16'h3E00 → 16'h0002 (tie to even, rounds up).
  - 16'h0200 × 16'h4400 → 16'h0800.
- Back-to-back: change a/b every cycle across the above vectors → each result appears exactly one edge after its operands, with no bubbles.

Source files
------------

// File: rtl/fpu16_pkg.sv
// Shared binary16 format definitions for the FPU16 cluster.
package fpu16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/fpu16_round_norm.sv
// Normalizes a raw 22-bit significand product, handles underflow into the
// subnormal range, rounds to nearest-even and saturates overflow to Inf.
module fpu16_round_norm
  import fpu16_pkg::*;
(
  input  logic              i_sign,
  input  logic signed [9:0] i_exp,
  input  logic [21:0]       i_prod,
  output logic [15:0]       o_result
);

  logic [4:0]        w_lz;
  logic              w_found;
  logic [21:0]       w_norm;
  logic signed [9:0] w_be;
  logic [4:0]        w_sh;
  logic [43:0]       w_wide;
  logic [10:0]       w_mant;
  logic              w_g;
  logic              w_st;
  logic              w_up;
  logic [11:0]       w_sum;
  logic signed [9:0] w_exp_fin;
  fp16_t             w_res;

  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int i = 21; i >= 0; i--) begin
      if (!w_found && i_prod[i]) begin
        w_lz    = 5'(21 - i);
        w_found = 1'b1;
      end
    end
  end

  // Product is value 1.x * 2^(i_exp+1) once bit 21 holds the leading one.
  assign w_norm = i_prod << w_lz;
  assign w_be   = i_exp + 10'sd16 - $signed({5'd0, w_lz});

  // Shifts past 22 leave nothing but sticky, so clamp the amount.
  always_comb begin
    w_sh = '0;
    if (w_be <= 10'sd0) begin
      if (w_be < -10'sd21) w_sh = 5'd23;
      else                 w_sh = 5'(10'sd1 - w_be);
    end
  end

  assign w_wide = {w_norm, 22'd0} >> w_sh;
  assign w_mant = w_wide[43:33];
  assign w_g    = w_wide[32];
  assign w_st   = |w_wide[31:0];
  assign w_up   = w_g & (w_st | w_mant[0]);
  assign w_sum  = {1'b0, w_mant} + {11'd0, w_up};

  // A subnormal rounding into bit 10 becomes the smallest normal.
  always_comb begin
    if (w_be <= 10'sd0) w_exp_fin = $signed({9'd0, w_sum[10]});
    else                w_exp_fin = w_be + $signed({9'd0, w_sum[11]});
  end

  always_comb begin
    w_res.sign = i_sign;
    w_res.exp  = w_exp_fin[4:0];
    w_res.frac = w_sum[9:0];
    if (w_exp_fin >= 10'sd31) begin
      w_res.exp  = 5'd31;
      w_res.frac = '0;
    end
  end

  assign o_result = w_res;

endmodule

// File: rtl/fpu16_multiplier.sv
// Binary16 multiplier: combinational decode/multiply/round into one output
// register, so each product appears one clock after its operands.
module fpu16_multiplier
  import fpu16_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_result
);

  fp16_t             w_a;
  fp16_t             w_b;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic              w_sign;
  logic [10:0]       w_ma, w_mb;
  logic [21:0]       w_prod;
  logic signed [9:0] w_ea, w_eb;
  logic [15:0]       w_rounded;
  logic [15:0]       w_next;
  logic [15:0]       r_result;

  assign w_a = i_a;
  assign w_b = i_b;

  assign w_a_zero = (w_a.exp == 5'd0)  && (w_a.frac == '0);
  assign w_b_zero = (w_b.exp == 5'd0)  && (w_b.frac == '0);
  assign w_a_inf  = (w_a.exp == 5'd31) && (w_a.frac == '0);
  assign w_b_inf  = (w_b.exp == 5'd31) && (w_b.frac == '0);
  assign w_a_nan  = (w_a.exp == 5'd31) && (w_a.frac != '0);
  assign w_b_nan  = (w_b.exp == 5'd31) && (w_b.frac != '0);
  assign w_sign   = w_a.sign ^ w_b.sign;

  assign w_ma   = {|w_a.exp, w_a.frac};
  assign w_mb   = {|w_b.exp, w_b.frac};
  assign w_prod = w_ma * w_mb;

  // Subnormals share the exponent of the smallest normal.
  assign w_ea = (w_a.exp == 5'd0) ? -10'sd14 : $signed({5'd0, w_a.exp}) - 10'(BIAS);
  assign w_eb = (w_b.exp == 5'd0) ? -10'sd14 : $signed({5'd0, w_b.exp}) - 10'(BIAS);

  fpu16_round_norm u_round_norm (
    .i_sign   (w_sign),
    .i_exp    (w_ea + w_eb),
    .i_prod   (w_prod),
    .o_result (w_rounded)
  );

  always_comb begin
    w_next = w_rounded;
    if (w_a_nan || w_b_nan)                                  w_next = QNAN;
    else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) w_next = QNAN;
    else if (w_a_inf || w_b_inf)                             w_next = {w_sign, POS_INF[14:0]};
    else if (w_a_zero || w_b_zero)                           w_next = {w_sign, 15'd0};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_result <= '0;
    else          r_result <= w_next;
  end

  assign o_result = r_result;

endmodule

// File: tb/tb_fpu16_multiplier.sv
// Directed-vector bench for fpu16_multiplier with hand-computed products.
module tb_fpu16_multiplier;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;

  int checks   = 0;
  int failures = 0;

  fpu16_multiplier dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_a      (a),
    .i_b      (b),
    .o_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a = 16'h3C00;
    b = 16'h3C00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_hold result=%h expected=%h", result, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_release_pre_edge result=%h expected=%h", result, 16'h0000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== 16'h3C00) begin
      failures++;
      $display("FAIL reset_first_result result=%h expected=%h", result, 16'h3C00);
    end
  endtask

  task automatic test_normal();
    logic [15:0] va [3] = '{16'hC524, 16'h562D, 16'hD1AE};
    logic [15:0] vb [3] = '{16'h4D90, 16'h5058, 16'h4947};
    logic [15:0] ve [3] = '{16'hD726, 16'h6AB5, 16'hDF7E};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      @(posedge clk);
      #1;
      checks++;
      if (result !== ve[i]) begin
        failures++;
        $display("FAIL normal[%0d] a=%h b=%h result=%h expected=%h", i, va[i], vb[i], result, ve[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [15:0] va [5] = '{16'h7C00, 16'h7E01, 16'hFC00, 16'h8000, 16'h0000};
    logic [15:0] vb [5] = '{16'h0000, 16'h3C00, 16'h4000, 16'h3C00, 16'hFC00};
    logic [15:0] ve [5] = '{16'h7E00, 16'h7E00, 16'hFC00, 16'h8000, 16'h7E00};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      @(posedge clk);
      #1;
      checks++;
      if (result !== ve[i]) begin
        failures++;
        $display("FAIL special[%0d] a=%h b=%h result=%h expected=%h", i, va[i], vb[i], result, ve[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] va [2] = '{16'h7BFF, 16'hFBFF};
    logic [15:0] vb [2] = '{16'h7BFF, 16'h7BFF};
    logic [15:0] ve [2] = '{16'h7C00, 16'hFC00};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      @(posedge clk);
      #1;
      checks++;
      if (result !== ve[i]) begin
        failures++;
        $display("FAIL overflow[%0d] a=%h b=%h result=%h expected=%h", i, va[i], vb[i], result, ve[i]);
      end
    end
  endtask

  task automatic test_subnormal();
    logic [15:0] va [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0200, 16'h03FF};
    logic [15:0] vb [5] = '{16'h3C00, 16'h3800, 16'h3E00, 16'h4400, 16'h3C01};
    logic [15:0] ve [5] = '{16'h0001, 16'h0000, 16'h0002, 16'h0800, 16'h0400};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      @(posedge clk);
      #1;
      checks++;
      if (result !== ve[i]) begin
        failures++;
        $display("FAIL subnormal[%0d] a=%h b=%h result=%h expected=%h", i, va[i], vb[i], result, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8] = '{16'hC524, 16'h7C00, 16'h562D, 16'h0001, 16'h7BFF, 16'h8000, 16'hD1AE, 16'h0200};
    logic [15:0] vb [8] = '{16'h4D90, 16'h0000, 16'h5058, 16'h3E00, 16'h7BFF, 16'h3C00, 16'h4947, 16'h4400};
    logic [15:0] ve [8] = '{16'hD726, 16'h7E00, 16'h6AB5, 16'h0002, 16'h7C00, 16'h8000, 16'hDF7E, 16'h0800};
    @(negedge clk);
    a = va[0];
    b = vb[0];
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (result !== ve[i]) begin
        failures++;
        $display("FAIL b2b[%0d] result=%h expected=%h", i, result, ve[i]);
      end
      if (i < 7) begin
        @(negedge clk);
        a = va[i+1];
        b = vb[i+1];
        #1;
        checks++;
        if (result !== ve[i]) begin
          failures++;
          $display("FAIL b2b_hold[%0d] result=%h expected=%h", i, result, ve[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 16'h4000;
    b = 16'h4000;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 16'h4400) begin
      failures++;
      $display("FAIL pre_async result=%h expected=%h", result, 16'h4400);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 16'h0000) begin
      failures++;
      $display("FAIL async_assert result=%h expected=%h", result, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 16'h4400) begin
      failures++;
      $display("FAIL async_release result=%h expected=%h", result, 16'h4400);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_normal();
    test_specials();
    test_overflow();
    test_subnormal();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
